// File: rtl/sha1_pkg.sv
// sha1_pkg
// Shared definitions for the SHA-1 compression stage:
//   - IV0..IV4 : standard SHA-1 initial chaining values
//   - K0..K3   : per-group round constants (rounds 0-19, 20-39, 40-59, 60-79)
//   - state_e  : controller states IDLE / ROUND / FINAL
//   - rotl1/5/30 : fixed-amount rotate-left helpers
//   - iv_word  : IV lookup by chaining-word index (0 = H0)
package sha1_pkg;

    localparam logic [31:0] IV0 = 32'h6745_2301;
    localparam logic [31:0] IV1 = 32'hEFCD_AB89;
    localparam logic [31:0] IV2 = 32'h98BA_DCFE;
    localparam logic [31:0] IV3 = 32'h1032_5476;
    localparam logic [31:0] IV4 = 32'hC3D2_E1F0;

    localparam logic [159:0] IV_CAT = {IV0, IV1, IV2, IV3, IV4};

    localparam logic [31:0] K0 = 32'h5A82_7999;
    localparam logic [31:0] K1 = 32'h6ED9_EBA1;
    localparam logic [31:0] K2 = 32'h8F1B_BCDC;
    localparam logic [31:0] K3 = 32'hCA62_C1D6;

    localparam logic [6:0] LAST_ROUND = 7'd79;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_e;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rotl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rotl30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    function automatic logic [31:0] iv_word(input int unsigned idx);
        logic [31:0] r;
        case (idx)
            0:       r = IV0;
            1:       r = IV1;
            2:       r = IV2;
            3:       r = IV3;
            default: r = IV4;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha1_round_func.sv
// sha1_round_func
// Purely combinational per-round mixing term: returns f_t(B,C,D) + K_t.
// Ports:
//   grp_i  [1:0]  : round group, t/20 (0..3)
//   b_i,c_i,d_i   : working words B, C, D
//   fk_o   [31:0] : f_t(B,C,D) + K_t, mod 2^32
module sha1_round_func
    import sha1_pkg::*;
(
    input  logic [1:0]  grp_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] fk_o
);

    logic [31:0] f_val;
    logic [31:0] k_val;

    always_comb begin
        f_val = b_i ^ c_i ^ d_i;
        k_val = K1;
        case (grp_i)
            2'd0: begin
                f_val = (b_i & c_i) | (~b_i & d_i);            // Ch
                k_val = K0;
            end
            2'd1: begin
                f_val = b_i ^ c_i ^ d_i;                       // Parity
                k_val = K1;
            end
            2'd2: begin
                f_val = (b_i & c_i) | (b_i & d_i) | (c_i & d_i); // Maj
                k_val = K2;
            end
            default: begin
                f_val = b_i ^ c_i ^ d_i;                       // Parity
                k_val = K3;
            end
        endcase
    end

    assign fk_o = f_val + k_val;

endmodule

// File: rtl/sha1_round_engine.sv
// sha1_round_engine
// SHA-1 compression stage fed one schedule word per cycle by the W engine.
// One block: start sampled in IDLE, 80 ROUND cycles, 1 FINAL cycle, then a
// one-cycle done pulse with the updated digest.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   start    : begin a block (sampled only in IDLE)
//   init_h   : with start, 1 = reload H from IV, 0 = chain from current H
//   w_in     : schedule word W[t], valid in every ROUND cycle
//   w_next   : advance strobe to the schedule engine (high in ROUND)
//   busy     : high in ROUND and FINAL
//   done     : one-cycle pulse, digest valid
//   digest   : {H0,H1,H2,H3,H4}
// Build option:
//   SHA1_DIGEST_REG_EN : digest comes from its own register, loaded together
//                        with done and held while the next block runs
//                        (reset value 0). Otherwise digest is wired to H.
module sha1_round_engine
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         init_h,
    input  logic [31:0]  w_in,
    output logic         w_next,
    output logic         busy,
    output logic         done,
    output logic [159:0] digest
);

    state_e state_q, state_d;
    logic [6:0]  t_q, t_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_q, c_d;
    logic [31:0] d_q, d_d;
    logic [31:0] e_q, e_d;
    logic        done_q, done_d;

    // Chaining words, index 0 = H0.
    logic [4:0][31:0] h_q, h_d;
    logic [4:0][31:0] iv_vec;
    logic [4:0][31:0] work_vec;
    logic [4:0][31:0] h_sum;

    logic [1:0]  grp;
    logic [31:0] fk;
    logic [31:0] t_word;

    assign work_vec[0] = a_q;
    assign work_vec[1] = b_q;
    assign work_vec[2] = c_q;
    assign work_vec[3] = d_q;
    assign work_vec[4] = e_q;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_hword
            assign iv_vec[gi] = iv_word(gi);
            assign h_sum[gi]  = h_q[gi] + work_vec[gi];
        end
    endgenerate

    always_comb begin
        if (t_q < 7'd20)      grp = 2'd0;
        else if (t_q < 7'd40) grp = 2'd1;
        else if (t_q < 7'd60) grp = 2'd2;
        else                  grp = 2'd3;
    end

    sha1_round_func u_round_func (
        .grp_i (grp),
        .b_i   (b_q),
        .c_i   (c_q),
        .d_i   (d_q),
        .fk_o  (fk)
    );

    assign t_word = rotl5(a_q) + fk + e_q + w_in;

    // w_next deliberately depends on state only, so the schedule engine's
    // word output can never loop back into its own advance strobe.
    assign w_next = (state_q == ROUND);
    assign busy   = (state_q == ROUND) || (state_q == FINAL);
    assign done   = done_q;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        e_d     = e_q;
        h_d     = h_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (init_h) begin
                        h_d = iv_vec;
                        a_d = iv_vec[0];
                        b_d = iv_vec[1];
                        c_d = iv_vec[2];
                        d_d = iv_vec[3];
                        e_d = iv_vec[4];
                    end else begin
                        a_d = h_q[0];
                        b_d = h_q[1];
                        c_d = h_q[2];
                        d_d = h_q[3];
                        e_d = h_q[4];
                    end
                    t_d     = 7'd0;
                    state_d = ROUND;
                end
            end

            ROUND: begin
                a_d = t_word;
                b_d = a_q;
                c_d = rotl30(b_q);
                d_d = c_q;
                e_d = d_q;
                if (t_q == LAST_ROUND) begin
                    // Wrap to 0 so t always stays within 0..79.
                    t_d     = 7'd0;
                    state_d = FINAL;
                end else begin
                    t_d = t_q + 7'd1;
                end
            end

            FINAL: begin
                h_d     = h_sum;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            t_q     <= 7'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            c_q     <= 32'd0;
            d_q     <= 32'd0;
            e_q     <= 32'd0;
            h_q     <= iv_vec;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            h_q     <= h_d;
            done_q  <= done_d;
        end
    end

`ifdef SHA1_DIGEST_REG_EN
    logic [159:0] digest_q, digest_d;

    // Loaded on the same edge that raises done, so it already carries the
    // new chaining value in the done cycle and is frozen thereafter.
    always_comb begin
        digest_d = digest_q;
        if (state_q == FINAL) begin
            digest_d = {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digest_q <= 160'd0;
        end else begin
            digest_q <= digest_d;
        end
    end

    assign digest = digest_q;
`else
    assign digest = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};
`endif

endmodule

// File: doc/sha1_round_engine.md
# sha1_round_engine

SHA-1 compression stage sitting directly downstream of the message-schedule (W) engine. Consumes one 32-bit schedule word W[t] per cycle for 80 rounds and drives the schedule engine's `next` advance strobe. Maintains the five 32-bit chaining words H0..H4 across blocks and presents the 160-bit digest after each block. One block takes 82 cycles from `start` to `done`.

## Interface
- `IV0..IV4`: 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0 (hex). Standard SHA-1 initial hash values.
- `clk` input 1: sole clock, rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begin compressing one block; sampled only in IDLE.
- `init_h` input 1: qualifies `start`; 1 = first block of a message (H reloaded from IV), 0 = chain from current H.
- `w_in` input 32: W[t] from the schedule engine's word output; must be valid in every ROUND cycle.
- `w_next` output 1: advance strobe to the schedule engine's `next`; high exactly in ROUND cycles.
- `busy` output 1: high in ROUND and FINAL.
- `done` output 1: one-cycle pulse; digest valid.
- `digest` output 160: {H0,H1,H2,H3,H4}, H0 in [159:128].

## Operation
- States: IDLE, ROUND, FINAL. Round counter t is 7 bits, 0..79.
- IDLE + `start`:
  - If `init_h`: H <= IV and A..E <= IV.
  - Otherwise: A..E <= H.
  - Then t <= 0 and go to ROUND.
- ROUND, each cycle:
  - T = ROTL5(A) + f_t(B,C,D) + E + K_t + w_in, mod 2^32.
  - E <= D; D <= C; C <= ROTL30(B); B <= A; A <= T.
  - t <= t+1.
  - After t==79, go to FINAL.
- f_t / K_t:
  - t 0–19: Ch = (B&C)|(~B&D), K 5A827999.
  - t 20–39: B^C^D, K 6ED9EBA1.
  - t 40–59: Maj = (B&C)|(B&D)|(C&D), K 8F1BBCDC.
  - t 60–79: B^C^D, K CA62C1D6.
- FINAL: Hi <= Hi + (A..E respectively), each mod 2^32. Then go to IDLE and register `done`=1 for the next cycle.
- `start` while busy is ignored; it is not queued.
- `start` in the same cycle as a `done` pulse (state IDLE) is accepted.
- The feed of the schedule engine with the next block is the controller's job. The feed must complete before `start`.
- The schedule engine's first word after feed must be W[0].

## Timing
- Cycle numbering: `start` sampled at edge 0.
  - ROUND occupies cycles 1–80, with `w_next`=1 and W[t] consumed at cycle t+1.
  - FINAL is cycle 81.
  - `done`=1 and the new `digest` are visible in cycle 82.
- `w_next` is combinational from state (state==ROUND). It has no dependency on `w_in`.
- `busy` is combinational from state.
- Reset values: state IDLE, t=0, A..E=0, H=IV, `done`=0, `w_next`=0, `busy`=0, `digest`=IV concatenation (with register option: 0).
- Reset asserted mid-block:
  - Immediate abort to the reset values.
  - No `done` is produced.
  - H is restored to IV.
- Without `init_h`, `digest` holds its value between blocks.

## Configuration
- `SHA1_DIGEST_REG_EN` defined:
  - `digest` comes from a separate 160-bit register, loaded only when `done` is raised. Reset value 0.
  - `digest` is stable while the next block runs.
- `SHA1_DIGEST_REG_EN` undefined:
  - `digest` is wired directly to H.
  - It changes at a `start` with `init_h`, and is valid only in the `done` cycle until the next `start`.

## Structure
- Shared package `sha1_pkg`: the IV0..IV4 and K0..K3 constants, the state enum {IDLE, ROUND, FINAL}, and ROTL helper functions.
- One sub-module, `sha1_round_func`: purely combinational. Takes the round-group select (t/20), B, C, D and returns f_t + K_t. This keeps the main datapath adder tree readable.
- The main module contains the FSM, the counter, A..E, H and the adders.

## Test plan
- Reset held, then released, no `start`:
  - `done`=0, `w_next`=0, `busy`=0.
  - `digest`=67452301EFCDAB8998BADCFE10325476C3D2E1F0 (0 with `SHA1_DIGEST_REG_EN`).
- Single-block "abc" padded, `init_h`=1, schedule engine connected:
  - Exactly 80 `w_next` cycles.
  - `done` in cycle 82.
  - `digest`=A9993E364706816ABA3E25717850C26C9CD0D89D.
- Empty message, padded block:
  - `digest`=DA39A3EE5E6B4B0D3255BFEF95601890AFD80709.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with `init_h`=1, block 2 with `init_h`=0.
  - Final `digest`=84983E441C3BD26EBAAE4AA1F95129E5E54670F1.
- `start` pulsed at cycles 10 and 81 of a running block:
  - Both are ignored.
  - Single `done` at cycle 82 with the correct "abc" digest.
  - `start` in the `done` cycle starts a new block (`busy` high the next cycle).
- `reset_n` low at cycle 40 of a block, then an "abc" block rerun:
  - No `done` from the aborted block.
  - Rerun gives A9993E36… correctly.
